// File: rtl/tx_arbiter.sv
// Round-robin arbiter that forwards one 32-bit word at a time from three
// requesters to a shared transmitter, then tracks the transmitter's busy handshake.
module tx_arbiter #(
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        hold,
  input  logic        busy,
  output logic [2:0]  ack,
  output logic        send,
  output logic [31:0] wrdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [1:0]  last_reg, last_next;
  logic [31:0] wrdata_reg, wrdata_next;
  logic [7:0]  cnt_reg, cnt_next;

  logic [1:0]  rot_idx [3];
  logic [2:0]  rot_req;
  logic [1:0]  grant_idx;
  logic        grant_ok;
  logic [31:0] grant_data;
  logic        busy_expired;

  function automatic logic [1:0] mod3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Requester order for this arbitration round, starting just after the last winner.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rot
    assign rot_idx[gi] = mod3({1'b0, last_reg} + 3'(gi) + 3'd1);
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  always_comb begin
    grant_idx = rot_idx[0];
    if (rot_req[0])      grant_idx = rot_idx[0];
    else if (rot_req[1]) grant_idx = rot_idx[1];
    else if (rot_req[2]) grant_idx = rot_idx[2];
  end

  always_comb begin
    grant_data = data0;
    case (grant_idx)
      2'd1:    grant_data = data1;
      2'd2:    grant_data = data2;
      default: grant_data = data0;
    endcase
  end

  // External transmitter activity (busy) also blocks a grant while idle.
  assign grant_ok     = (state_reg == IDLE) && !hold && !busy && (req != 3'b000);
  assign busy_expired = !busy && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next  = state_reg;
    last_next   = last_reg;
    wrdata_next = wrdata_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (grant_ok) begin
          state_next  = SEND;
          last_next   = grant_idx;
          wrdata_next = grant_data;
        end
      end
      SEND: begin
        state_next = WAIT_BUSY;
        cnt_next   = 8'd0;
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_next = WAIT_DONE;
        end else if (busy_expired) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      last_reg   <= 2'd2;
      wrdata_reg <= 32'd0;
      cnt_reg    <= 8'd0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      wrdata_reg <= wrdata_next;
      cnt_reg    <= cnt_next;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ack
    assign ack[gi] = (state_reg == SEND) && (last_reg == 2'(gi));
  end

  assign send        = (state_reg == SEND);
  assign wrdata      = wrdata_reg;
  assign timeout_err = (state_reg == WAIT_BUSY) && busy_expired;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: transfer-level reference model compared
// every cycle, directed scenarios with literal timing, then randomized traffic.
module tb_tx_arbiter;

  localparam int BT = 16;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [31:0] data0 = '0, data1 = '0, data2 = '0;
  logic        hold = 1'b0;
  logic        busy;
  logic        busy_man = 1'b0;
  logic        busy_auto;
  logic        xm_en = 1'b0;
  logic        xm_rand = 1'b0;
  int          xm_delay = 2;
  int          xm_len = 10;
  logic [2:0]  ack;
  logic        send;
  logic [31:0] wrdata;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int ack_q[$];
  int wr_q[$];
  int scyc_q[$];
  int to_q[$];

  assign busy = xm_en ? busy_auto : busy_man;

  tx_arbiter #(.BUSY_TIMEOUT(BT)) dut (
    .clock(clk), .reset(srst), .req(req), .data0(data0), .data1(data1),
    .data2(data2), .hold(hold), .busy(busy), .ack(ack), .send(send),
    .wrdata(wrdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Transfer-level reference: a word granted at an edge is sent for one cycle,
  // then waits for busy (up to BT cycles) and for busy to clear.
  logic        m_snd = 1'b0;
  logic        m_xfer = 1'b0;
  logic        m_gotb = 1'b0;
  int          m_wait = 0;
  int          m_last = 2;
  logic [31:0] m_word = '0;

  function automatic logic [31:0] pick_data(input int idx);
    case (idx)
      0: return data0;
      1: return data1;
      default: return data2;
    endcase
  endfunction

  task automatic model_edge();
    if (srst) begin
      m_snd = 0; m_xfer = 0; m_gotb = 0; m_wait = 0; m_last = 2; m_word = '0;
    end else if (m_snd) begin
      m_snd = 0; m_xfer = 1; m_gotb = 0; m_wait = 0;
    end else if (m_xfer) begin
      if (!m_gotb) begin
        if (busy) m_gotb = 1;
        else if (m_wait == BT - 1) m_xfer = 0;
        else m_wait++;
      end else if (!busy) begin
        m_xfer = 0;
      end
    end else if (!hold && !busy && req != 3'b000) begin
      for (int k = 1; k <= 3; k++) begin
        int idx;
        idx = (m_last + k) % 3;
        if (req[idx]) begin
          m_last = idx;
          m_word = pick_data(idx);
          m_snd  = 1;
          break;
        end
      end
    end
  endtask

  // Single compare process: check at the falling edge, advance the model at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        logic [2:0] e_ack;
        logic       e_to;
        e_ack = m_snd ? 3'(1 << m_last) : 3'b000;
        e_to  = m_xfer && !m_gotb && !busy && (m_wait == BT - 1);
        chk("send", 32'(send), 32'(m_snd));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("wrdata", wrdata, m_word);
        chk("timeout_err", 32'(timeout_err), 32'(e_to));
        if (send) begin
          ack_q.push_back(int'(ack));
          wr_q.push_back(int'(wrdata));
          scyc_q.push_back(cyc);
          $display("[TB] cycle %0d send ack=%b wrdata=%h", cyc, ack, wrdata);
        end
        if (timeout_err) to_q.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      model_edge();
    end
  end

  // Transmitter model: raises busy some cycles after each send, holds it, drops it.
  initial begin
    busy_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (xm_en && send) begin
        int d, l;
        d = xm_rand ? int'($urandom_range(1, 20)) : xm_delay;
        l = xm_rand ? int'($urandom_range(1, 6)) : xm_len;
        repeat (d) @(posedge clk);
        #1 busy_auto = 1'b1;
        repeat (l) @(posedge clk);
        #1 busy_auto = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    ack_q.delete(); wr_q.delete(); scyc_q.delete(); to_q.delete();
  endtask

  task automatic do_reset();
    srst = 1'b1; req = 3'b000; hold = 1'b0; busy_man = 1'b0;
    tick(1);
    srst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_sends(input int n, input int budget);
    int b;
    b = budget;
    while (ack_q.size() < n && b > 0) begin
      tick(1);
      b--;
    end
    chk("send_within_budget", 32'(ack_q.size() >= n), 32'd1);
  endtask

  initial begin
    int hcyc, rcyc;
    tick(3);
    chk("reset_wrdata", wrdata, 32'd0);
    chk("reset_send", 32'(send), 32'd0);

    // Single requester with transmitter answering 2 cycles after send.
    do_reset();
    xm_en = 1; xm_rand = 0; xm_delay = 2; xm_len = 10;
    data0 = 32'h12345678; req = 3'b001;
    wait_sends(1, 20);
    data0 = 32'hCAFEF00D;
    wait_sends(2, 40);
    req = 3'b000;
    chk("s1_ack0", 32'(ack_q[0]), 32'd1);
    chk("s1_word0", 32'(wr_q[0]), 32'h12345678);
    chk("s1_ack1", 32'(ack_q[1]), 32'd1);
    chk("s1_word1", 32'(wr_q[1]), 32'hCAFEF00D);
    chk("s1_regrant_gap", 32'(scyc_q[1] - scyc_q[0]), 32'd14);
    tick(20);

    // All three requesting: strict rotation.
    do_reset();
    xm_delay = 1; xm_len = 3;
    data0 = 32'hA0A0A0A0; data1 = 32'hB1B1B1B1; data2 = 32'hC2C2C2C2;
    req = 3'b111;
    wait_sends(4, 200);
    req = 3'b000;
    chk("rr_ack0", 32'(ack_q[0]), 32'd1);
    chk("rr_ack1", 32'(ack_q[1]), 32'd2);
    chk("rr_ack2", 32'(ack_q[2]), 32'd4);
    chk("rr_ack3", 32'(ack_q[3]), 32'd1);
    chk("rr_word1", 32'(wr_q[1]), 32'hB1B1B1B1);
    chk("rr_word2", 32'(wr_q[2]), 32'hC2C2C2C2);
    tick(20);

    // Transmitter never answers: timeout then re-grant.
    do_reset();
    xm_en = 0; req = 3'b001;
    wait_sends(1, 10);
    begin
      int b;
      b = 40;
      while (to_q.size() < 1 && b > 0) begin
        tick(1);
        b--;
      end
      chk("timeout_seen", 32'(to_q.size()), 32'd1);
    end
    wait_sends(2, 10);
    req = 3'b000;
    chk("timeout_delay", 32'(to_q[0] - scyc_q[0]), 32'd16);
    chk("timeout_regrant", 32'(scyc_q[1] - to_q[0]), 32'd2);
    tick(40);

    // hold blocks grants; release gives send one cycle later.
    do_reset();
    hold = 1; req = 3'b010;
    tick(20);
    chk("hold_no_send", 32'(ack_q.size()), 32'd0);
    hcyc = cyc; hold = 0;
    wait_sends(1, 10);
    req = 3'b000;
    chk("hold_release_latency", 32'(scyc_q[0] - hcyc), 32'd1);
    chk("hold_ack", 32'(ack_q[0]), 32'd2);
    tick(40);

    // Busy from foreign traffic while idle.
    do_reset();
    busy_man = 1; req = 3'b001;
    tick(10);
    chk("busy_idle_no_send", 32'(ack_q.size()), 32'd0);
    hcyc = cyc; busy_man = 0;
    wait_sends(1, 10);
    req = 3'b000;
    chk("busy_release_latency", 32'(scyc_q[0] - hcyc), 32'd1);
    tick(40);

    // Reset during WAIT_DONE.
    do_reset();
    xm_en = 1; xm_delay = 1; xm_len = 20; req = 3'b001;
    wait_sends(1, 20);
    req = 3'b000;
    tick(3);
    srst = 1; xm_en = 0; busy_man = 0; rcyc = cyc;
    tick(1);
    srst = 0; req = 3'b110;
    clear_logs();
    chk("rst_mid_send", 32'(send), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_wrdata", wrdata, 32'd0);
    chk("rst_mid_to", 32'(timeout_err), 32'd0);
    wait_sends(1, 10);
    req = 3'b000;
    chk("rst_mid_first_ack", 32'(ack_q[0]), 32'd2);
    chk("rst_mid_latency", 32'(scyc_q[0] - rcyc), 32'd2);
    tick(40);

    // Randomized traffic against the model.
    xm_en = 1; xm_rand = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      hold  = ($urandom_range(0, 7) == 0);
      srst  = ($urandom_range(0, 299) == 0);
      data0 = $urandom; data1 = $urandom; data2 = $urandom;
      tick(1);
    end
    srst = 0; req = 3'b000; hold = 0;
    tick(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 16: max cycles in WAIT_BUSY for the transmitter to raise busy after send; legal range 2..255.
REQ-002 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 req  input  3  per-requester transmit request; bit i belongs to requester i.
REQ-005 data0  input  32  word from requester 0.
REQ-006 data1  input  32  word from requester 1.
REQ-007 data2  input  32  word from requester 2.
REQ-008 hold  input  1  flow-control pause (xoff level); when high, blocks new grants only.
REQ-009 busy  input  1  transmitter busy flag.
REQ-010 ack  output  3  one-hot, one-cycle pulse to the requester whose word is being sent.
REQ-011 send  output  1  one-cycle pulse to the transmitter write strobe.
REQ-012 wrdata  output  32  word presented to the transmitter.
REQ-013 timeout_err  output  1  one-cycle pulse when the transmitter never raised busy.

Function
REQ-014 FSM states SHALL be IDLE, SEND, WAIT_BUSY and WAIT_DONE, encoded in registers.
REQ-015 IDLE: a grant SHALL occur only when hold=0, busy=0 and req!=0; otherwise the FSM stays in IDLE.
REQ-016 Grant SHALL be round-robin: search order starts at (last+1) mod 3, wraps, and picks the first set req bit.
REQ-017 At grant, wrdata SHALL load the selected dataN, last SHALL load the granted index, and the FSM SHALL enter SEND next cycle.
REQ-018 SEND: send=1 and ack[last]=1 for exactly this one cycle; next state WAIT_BUSY; the 8-bit timeout counter clears to 0.
REQ-019 WAIT_BUSY with busy=1 SHALL move to WAIT_DONE.
REQ-020 WAIT_BUSY with busy=0 SHALL increment the counter.
REQ-021 When the counter equals BUSY_TIMEOUT-1 with busy=0, the FSM SHALL return to IDLE and pulse timeout_err for one cycle.
REQ-022 WAIT_DONE SHALL move to IDLE on the first cycle busy=0.
REQ-023 The grant-to-send latency SHALL be exactly 1 cycle: req seen in IDLE at cycle N gives send/ack at cycle N+1.
REQ-024 The earliest re-grant after busy falls SHALL be 1 cycle: the FSM enters IDLE, then the next grant is evaluated there.
REQ-025 wrdata SHALL remain stable from grant until the FSM re-enters IDLE; dataN changes after grant SHALL have no effect.
REQ-026 Requesters hold req high until ack; a req bit dropped before grant is simply not considered.
REQ-027 A req bit still high in the cycle after its ack SHALL be a new request.
REQ-028 hold rising during SEND, WAIT_BUSY or WAIT_DONE SHALL NOT abort the transfer in progress; it only blocks the next grant.
REQ-029 If a requester's req and hold both rise in the same cycle, there SHALL be no grant.
REQ-030 busy high while in IDLE SHALL block grants, covering transmitter activity not issued by this block (ID/xon replies).
REQ-031 ack SHALL be zero or one-hot at all times, and send SHALL equal |ack.
REQ-032 With all three req bits held high continuously, grants SHALL rotate 0,1,2,0,… with no requester skipped.

Reset
REQ-033 Reset SHALL force state=IDLE, send=0, ack=0, timeout_err=0, wrdata=0, counter=0 and last=2, so requester 0 has first priority.
REQ-034 Reset asserted in any state, including mid-transfer, SHALL take effect on the next edge and discard the latched word with no ack.
REQ-035 No grant SHALL occur in the cycle reset is high.

Verification
REQ-036 Bench: reset, then req=3'b001 with data0=0x12345678 and busy rising 2 cycles after send, held 10 cycles -> one send/ack[0] pulse, wrdata=0x12345678 until IDLE, then a re-grant while req0 is held.
REQ-037 Bench: req=3'b111 held with the transmitter model cycling busy -> ack order 001,010,100,001, and wrdata matches data0/1/2 in turn.
REQ-038 Bench: busy never rises after send, BUSY_TIMEOUT=16 -> timeout_err pulses exactly 16 cycles after the SEND cycle, then the FSM returns to IDLE and re-grants.
REQ-039 Bench: hold=1 with req=3'b010 -> no send for 20 cycles; hold drops -> send/ack[1] one cycle later.
REQ-040 Bench: reset asserted in WAIT_DONE -> next cycle all outputs are 0, last=2, and a fresh req=3'b110 is granted to requester 1 first.
REQ-041 Bench: busy=1 in IDLE from an external ID reply, req=3'b001 -> no grant until busy=0, then send on the following cycle.
